// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
// The pointer type carries one extra wrap bit above the memory address.
package fifo_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction

  typedef logic [ASIZE_DEF:0] ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DSIZE array with a clocked write port and an
// asynchronous read port, so the head word is visible without a read cycle.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             wclk,
  input  logic             wen,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = depth_of(ASIZE);

  logic [DSIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge wclk) begin
    if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/async_fifo_1.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// Flags and read data depend only on registered pointers and the array.
module async_fifo_1
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
);

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic             write_ok;
  logic             read_ok;
  logic             mem_wen;
  logic [DSIZE-1:0] mem_rdata;

  // Same address with opposite wrap bits means the writer is a full lap ahead.
  assign rempty = (wptr_q == rptr_q);
  assign wfull  = (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]) &&
                  (wptr_q[ASIZE] != rptr_q[ASIZE]);

  assign write_ok = winc && !wfull;
  assign read_ok  = rinc && !rempty;
  assign mem_wen  = write_ok && !wrst;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (write_ok) begin
      wptr_d = wptr_q + {{ASIZE{1'b0}}, 1'b1};
    end
    if (read_ok) begin
      rptr_d = rptr_q + {{ASIZE{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  fifo_mem #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem (
    .wclk  (wclk),
    .wen   (mem_wen),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  assign rdata = rempty ? '0 : mem_rdata;

endmodule

// File: tb/tb_async_fifo_1.sv
// Randomized and directed checks of async_fifo_1 against a queue model.
module tb_async_fifo_1;

  localparam int DEPTH = 16;

  logic       wclk;
  logic       wrst;
  logic [7:0] wdata;
  logic       winc;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_q[$];

  async_fifo_1 dut (
    .wclk   (wclk),
    .wrst   (wrst),
    .wdata  (wdata),
    .winc   (winc),
    .rinc   (rinc),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then compare flags and head.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic rst);
    bit was_full;
    bit was_empty;
    winc  = w;
    rinc  = r;
    wdata = d;
    wrst  = rst;
    @(posedge wclk);
    if (rst) begin
      model_q.delete();
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (r && !was_empty) void'(model_q.pop_front());
      if (w && !was_full) model_q.push_back(d);
    end
    @(negedge wclk);
    $display("cyc rst=%b w=%b r=%b d=%02h -> occ=%0d rdata=%02h full=%b empty=%b",
             rst, w, r, d, model_q.size(), rdata, wfull, rempty);
    check("rempty", {31'd0, rempty}, {31'd0, model_q.size() == 0});
    check("wfull", {31'd0, wfull}, {31'd0, model_q.size() == DEPTH});
    check("rdata", {24'd0, rdata}, {24'd0, (model_q.size() == 0) ? 8'h00 : model_q[0]});
  endtask

  initial begin
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = 8'h00;
    wrst  = 1'b1;

    // Reset held with both requests asserted
    cycle(1'b1, 1'b1, 8'h33, 1'b1);
    cycle(1'b1, 1'b1, 8'h44, 1'b1);
    check("rst_empty", {31'd0, rempty}, 32'd1);
    check("rst_full", {31'd0, wfull}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);

    // Fill, then an ignored write while full
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i + 1), 1'b0);
    check("fill_full", {31'd0, wfull}, 32'd1);
    cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    check("full_head", {24'd0, rdata}, 32'h01);

    // Drain in order; the consumer samples rdata in the cycle it pops
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_seq", {24'd0, rdata}, 32'(i + 1));
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("drain_empty", {31'd0, rempty}, 32'd1);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("empty_rdata", {24'd0, rdata}, 32'd0);

    // Steady-state simultaneous traffic across pointer wrap
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
      check("simul_empty", {31'd0, rempty}, 32'd0);
      check("simul_full", {31'd0, wfull}, 32'd0);
    end

    // Full with both asserted: pop happens, push dropped
    while (model_q.size() < DEPTH) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    check("full_both", {31'd0, wfull}, 32'd0);
    while (model_q.size() > 0) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Empty with both asserted: push happens, pop dropped
    cycle(1'b1, 1'b1, 8'h5A, 1'b0);
    check("empty_both", {24'd0, rdata}, 32'h5A);
    check("empty_both_flag", {31'd0, rempty}, 32'd0);

    // Mid-operation reset discards contents
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("midrst_empty", {31'd0, rempty}, 32'd1);
    check("midrst_rdata", {24'd0, rdata}, 32'd0);
    cycle(1'b1, 1'b0, 8'hA5, 1'b0);
    check("midrst_write", {24'd0, rdata}, 32'hA5);

    // Random traffic with write-heavy and read-heavy phases and rare resets
    for (int i = 0; i < 600; i++) begin
      int wbias;
      wbias = ((i / 100) % 2 == 0) ? 70 : 30;
      cycle($urandom_range(99) < wbias, $urandom_range(99) < (100 - wbias),
            8'($urandom), $urandom_range(199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
